// File: rtl/dispatch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dispatch_queue (with package dispatch_queue_pkg)             |
// | Description : Two-wide in-order circular buffer between decode and         |
// |               issue/rename. Accepts up to two instructions per cycle,      |
// |               delivers up to two per cycle, and forces special and         |
// |               excepting instructions to leave the head alone.              |
// | Ports       : clk, resetn (async active-low), flush (sync, top priority)   |
// |               enq_valid[1:0], enq_inst/pc/ex 1..2, enq_ready               |
// |               deq_valid[1:0], deq_inst/pc/ex 1..2, deq_ready[1:0]          |
// |               count (occupancy, $clog2(DEPTH)+1 bits)                      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+

package dispatch_queue_pkg;
  typedef logic [31:0] virt_t;

  typedef struct packed {
    logic [15:0] opcode;
    logic        is_sp_op;
  } decoded_inst_t;

  typedef struct packed {
    logic       ex;
    logic [4:0] exccode;
  } exception_t;

  localparam logic [4:0] EXC_RI = 5'd10;
endpackage

module dispatch_queue
  import dispatch_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       flush,
  input  logic [1:0]                 enq_valid,
  input  decoded_inst_t              enq_inst1,
  input  decoded_inst_t              enq_inst2,
  input  virt_t                      enq_pc1,
  input  virt_t                      enq_pc2,
  input  exception_t                 enq_ex1,
  input  exception_t                 enq_ex2,
  output logic                       enq_ready,
  output logic [1:0]                 deq_valid,
  output decoded_inst_t              deq_inst1,
  output decoded_inst_t              deq_inst2,
  output virt_t                      deq_pc1,
  output virt_t                      deq_pc2,
  output exception_t                 deq_ex1,
  output exception_t                 deq_ex2,
  input  logic [1:0]                 deq_ready,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] C_ENQ_MAX = CW'(DEPTH - 2);
  localparam logic [CW-1:0] C_TWO     = CW'(2);

  typedef struct packed {
    decoded_inst_t inst;
    virt_t         pc;
    exception_t    ex;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_count;

  logic [PW-1:0]   w_head_next;
  logic [PW-1:0]   w_slot2_idx;
  logic            w_head_single;
  logic            w_next_single;
  logic            w_enq_fire;
  logic [1:0]      w_n_enq;
  logic [1:0]      w_n_deq;

  // Head+1 wraps naturally because the pointer width matches the depth.
  assign w_head_next = r_head + PW'(1);

  assign deq_inst1 = mem[r_head].inst;
  assign deq_pc1   = mem[r_head].pc;
  assign deq_ex1   = mem[r_head].ex;
  assign deq_inst2 = mem[w_head_next].inst;
  assign deq_pc2   = mem[w_head_next].pc;
  assign deq_ex2   = mem[w_head_next].ex;

  // An excepting or special entry at either head slot blocks dual issue.
  assign w_head_single = mem[r_head].ex.ex      | mem[r_head].inst.is_sp_op;
  assign w_next_single = mem[w_head_next].ex.ex | mem[w_head_next].inst.is_sp_op;

  assign count        = r_count;
  assign enq_ready    = (r_count <= C_ENQ_MAX);
  assign deq_valid[0] = (r_count != '0);
  assign deq_valid[1] = (r_count >= C_TWO) & ~w_head_single & ~w_next_single;

  assign w_enq_fire = enq_ready & ~flush;
  assign w_n_enq    = w_enq_fire ? ({1'b0, enq_valid[0]} + {1'b0, enq_valid[1]}) : 2'd0;

  // deq_ready is thermometer coded: slot 2 only counts when slot 1 is taken.
  always_comb begin
    w_n_deq = 2'd0;
    if (deq_valid[1] && deq_ready[1] && deq_ready[0]) begin
      w_n_deq = 2'd2;
    end else if (deq_valid[0] && deq_ready[0]) begin
      w_n_deq = 2'd1;
    end
  end

  // Slot 2 lands right after slot 1 only when slot 1 is actually present.
  assign w_slot2_idx = r_tail + PW'(enq_valid[0]);

  // Storage has no reset; only valid occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_enq_fire && enq_valid[0]) begin
      mem[r_tail] <= '{inst: enq_inst1, pc: enq_pc1, ex: enq_ex1};
    end
    if (w_enq_fire && enq_valid[1]) begin
      mem[w_slot2_idx] <= '{inst: enq_inst2, pc: enq_pc2, ex: enq_ex2};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PW'(w_n_deq);
      r_tail  <= r_tail + PW'(w_n_enq);
      r_count <= r_count + CW'(w_n_enq) - CW'(w_n_deq);
    end
  end

  a_count_bound: assert property (@(posedge clk) disable iff (!resetn)
    r_count <= CW'(DEPTH));

  a_ptr_consistent: assert property (@(posedge clk) disable iff (!resetn)
    !flush |-> ((r_tail - r_head) == r_count[PW-1:0]));

endmodule

`default_nettype wire

// File: tb/tb_dispatch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_dispatch_queue                                            |
// | Description : Self-checking bench for dispatch_queue: directed vector      |
// |               table, mid-operation reset, and random traffic compared      |
// |               against a queue-based reference model.                       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_dispatch_queue;
  import dispatch_queue_pkg::*;

  localparam int DEPTH = 8;

  typedef struct packed {
    decoded_inst_t inst;
    virt_t         pc;
    exception_t    ex;
  } tb_ent_t;

  typedef struct {
    logic        fl;
    logic [1:0]  ev;
    logic [31:0] pc1;
    logic [31:0] pc2;
    logic        sp1;
    logic        sp2;
    logic        ex1;
    logic        ex2;
    logic [1:0]  dr;
    int          cnt;
    logic        er;
    logic [1:0]  dv;
    logic [31:0] o1;
    logic [31:0] o2;
    logic        oex;
  } vec_t;

  logic                   clk;
  logic                   resetn;
  logic                   flush;
  logic [1:0]             enq_valid;
  decoded_inst_t          enq_inst1, enq_inst2;
  virt_t                  enq_pc1, enq_pc2;
  exception_t             enq_ex1, enq_ex2;
  logic                   enq_ready;
  logic [1:0]             deq_valid;
  decoded_inst_t          deq_inst1, deq_inst2;
  virt_t                  deq_pc1, deq_pc2;
  exception_t             deq_ex1, deq_ex2;
  logic [1:0]             deq_ready;
  logic [$clog2(DEPTH):0] count;

  dispatch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .enq_valid(enq_valid),
    .enq_inst1(enq_inst1), .enq_inst2(enq_inst2),
    .enq_pc1(enq_pc1), .enq_pc2(enq_pc2),
    .enq_ex1(enq_ex1), .enq_ex2(enq_ex2),
    .enq_ready(enq_ready),
    .deq_valid(deq_valid),
    .deq_inst1(deq_inst1), .deq_inst2(deq_inst2),
    .deq_pc1(deq_pc1), .deq_pc2(deq_pc2),
    .deq_ex1(deq_ex1), .deq_ex2(deq_ex2),
    .deq_ready(deq_ready),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  tb_ent_t    mq[$];
  vec_t       vt[$];
  logic       cur_fl;
  logic [1:0] cur_ev;
  logic [1:0] cur_dr;
  tb_ent_t    cur_s1, cur_s2;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic tb_ent_t mk(input logic [31:0] pc, input logic sp, input logic ex);
    tb_ent_t e;
    e.pc            = pc;
    e.inst.opcode   = pc[15:0];
    e.inst.is_sp_op = sp;
    e.ex.ex         = ex;
    e.ex.exccode    = ex ? EXC_RI : 5'd0;
    return e;
  endfunction

  // Reference view: dual issue needs two entries, neither special nor excepting.
  function automatic logic [1:0] model_dv();
    logic [1:0] dv;
    dv[0] = (mq.size() >= 1);
    dv[1] = (mq.size() >= 2) && !mq[0].inst.is_sp_op && !mq[0].ex.ex &&
            !mq[1].inst.is_sp_op && !mq[1].ex.ex;
    return dv;
  endfunction

  task automatic drive(input logic fl, input logic [1:0] ev, input tb_ent_t s1,
                       input tb_ent_t s2, input logic [1:0] dr);
    flush = fl; enq_valid = ev; deq_ready = dr;
    enq_inst1 = s1.inst; enq_pc1 = s1.pc; enq_ex1 = s1.ex;
    enq_inst2 = s2.inst; enq_pc2 = s2.pc; enq_ex2 = s2.ex;
    cur_fl = fl; cur_ev = ev; cur_dr = dr; cur_s1 = s1; cur_s2 = s2;
  endtask

  task automatic model_check();
    chk("m_count", 64'(count), 64'(mq.size()));
    chk("m_enq_ready", 64'(enq_ready), 64'(mq.size() <= DEPTH - 2));
    chk("m_deq_valid", 64'(deq_valid), 64'(model_dv()));
    if (mq.size() >= 1) begin
      chk("m_pc1", 64'(deq_pc1), 64'(mq[0].pc));
      chk("m_inst1", 64'(deq_inst1), 64'(mq[0].inst));
      chk("m_ex1", 64'(deq_ex1), 64'(mq[0].ex));
    end
    if (mq.size() >= 2) begin
      chk("m_pc2", 64'(deq_pc2), 64'(mq[1].pc));
      chk("m_inst2", 64'(deq_inst2), 64'(mq[1].inst));
      chk("m_ex2", 64'(deq_ex2), 64'(mq[1].ex));
    end
  endtask

  task automatic model_step();
    logic [1:0] dv;
    bit         can_enq;
    int         n;
    if (cur_fl) begin
      mq.delete();
    end else begin
      can_enq = (mq.size() <= DEPTH - 2);
      dv = model_dv();
      if (dv[1] && cur_dr == 2'b11)   n = 2;
      else if (dv[0] && cur_dr[0])    n = 1;
      else                            n = 0;
      repeat (n) void'(mq.pop_front());
      if (can_enq) begin
        if (cur_ev[0]) mq.push_back(cur_s1);
        if (cur_ev[1]) mq.push_back(cur_s2);
      end
    end
  endtask

  task automatic run_cycle(input logic fl, input logic [1:0] ev, input tb_ent_t s1,
                           input tb_ent_t s2, input logic [1:0] dr);
    drive(fl, ev, s1, s2, dr);
    @(negedge clk);
    model_check();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic add(input logic fl, input logic [1:0] ev, input logic [31:0] pc1,
                     input logic [31:0] pc2, input logic sp1, input logic sp2,
                     input logic ex1, input logic ex2, input logic [1:0] dr,
                     input int cnt, input logic er, input logic [1:0] dv,
                     input logic [31:0] o1, input logic [31:0] o2, input logic oex);
    vec_t v;
    v.fl = fl; v.ev = ev; v.pc1 = pc1; v.pc2 = pc2; v.sp1 = sp1; v.sp2 = sp2;
    v.ex1 = ex1; v.ex2 = ex2; v.dr = dr; v.cnt = cnt; v.er = er; v.dv = dv;
    v.o1 = o1; v.o2 = o2; v.oex = oex;
    vt.push_back(v);
  endtask

  initial begin
    tb_ent_t    z;
    exception_t exp_ex;
    z = mk(32'h0, 1'b0, 1'b0);

    // Expected values are those observed during the cycle, before its edge.
    //  fl ev  pc1       pc2       sp1 sp2 ex1 ex2 dr   cnt er dv  o1        o2        oex
    add(0, 3, 32'h100, 32'h104, 0, 0, 0, 0, 2'b00, 0, 1, 0, 32'h0,   32'h0,   0);
    add(0, 3, 32'h108, 32'h10C, 0, 0, 0, 0, 2'b00, 2, 1, 3, 32'h100, 32'h104, 0);
    add(0, 3, 32'h110, 32'h114, 0, 0, 0, 0, 2'b00, 4, 1, 3, 32'h100, 32'h104, 0);
    add(0, 3, 32'h118, 32'h11C, 0, 0, 0, 0, 2'b00, 6, 1, 3, 32'h100, 32'h104, 0);
    add(0, 3, 32'h500, 32'h504, 0, 0, 0, 0, 2'b00, 8, 0, 3, 32'h100, 32'h104, 0);
    add(0, 0, 32'h0,   32'h0,   0, 0, 0, 0, 2'b11, 8, 0, 3, 32'h100, 32'h104, 0);
    add(0, 0, 32'h0,   32'h0,   0, 0, 0, 0, 2'b11, 6, 1, 3, 32'h108, 32'h10C, 0);
    add(0, 0, 32'h0,   32'h0,   0, 0, 0, 0, 2'b11, 4, 1, 3, 32'h110, 32'h114, 0);
    add(0, 0, 32'h0,   32'h0,   0, 0, 0, 0, 2'b11, 2, 1, 3, 32'h118, 32'h11C, 0);
    add(0, 0, 32'h0,   32'h0,   0, 0, 0, 0, 2'b00, 0, 1, 0, 32'h0,   32'h0,   0);
    // special op between two ALU ops
    add(0, 3, 32'h200, 32'h204, 0, 1, 0, 0, 2'b11, 0, 1, 0, 32'h0,   32'h0,   0);
    add(0, 1, 32'h208, 32'h0,   0, 0, 0, 0, 2'b11, 2, 1, 1, 32'h200, 32'h0,   0);
    add(0, 0, 32'h0,   32'h0,   0, 0, 0, 0, 2'b11, 2, 1, 1, 32'h204, 32'h0,   0);
    add(0, 0, 32'h0,   32'h0,   0, 0, 0, 0, 2'b11, 1, 1, 1, 32'h208, 32'h0,   0);
    add(0, 0, 32'h0,   32'h0,   0, 0, 0, 0, 2'b00, 0, 1, 0, 32'h0,   32'h0,   0);
    // excepting instruction at head
    add(0, 3, 32'h300, 32'h304, 0, 0, 1, 0, 2'b00, 0, 1, 0, 32'h0,   32'h0,   0);
    add(0, 0, 32'h0,   32'h0,   0, 0, 0, 0, 2'b11, 2, 1, 1, 32'h300, 32'h0,   1);
    add(0, 0, 32'h0,   32'h0,   0, 0, 0, 0, 2'b11, 1, 1, 1, 32'h304, 32'h0,   0);
    add(0, 0, 32'h0,   32'h0,   0, 0, 0, 0, 2'b00, 0, 1, 0, 32'h0,   32'h0,   0);
    // occupancy 6 with simultaneous enq/deq and tail wrap
    add(0, 3, 32'h600, 32'h604, 0, 0, 0, 0, 2'b00, 0, 1, 0, 32'h0,   32'h0,   0);
    add(0, 3, 32'h608, 32'h60C, 0, 0, 0, 0, 2'b00, 2, 1, 3, 32'h600, 32'h604, 0);
    add(0, 3, 32'h610, 32'h614, 0, 0, 0, 0, 2'b00, 4, 1, 3, 32'h600, 32'h604, 0);
    add(0, 3, 32'h618, 32'h61C, 0, 0, 0, 0, 2'b11, 6, 1, 3, 32'h600, 32'h604, 0);
    add(0, 0, 32'h0,   32'h0,   0, 0, 0, 0, 2'b11, 6, 1, 3, 32'h608, 32'h60C, 0);
    add(0, 0, 32'h0,   32'h0,   0, 0, 0, 0, 2'b11, 4, 1, 3, 32'h610, 32'h614, 0);
    add(0, 0, 32'h0,   32'h0,   0, 0, 0, 0, 2'b11, 2, 1, 3, 32'h618, 32'h61C, 0);
    add(0, 0, 32'h0,   32'h0,   0, 0, 0, 0, 2'b00, 0, 1, 0, 32'h0,   32'h0,   0);
    // flush at occupancy 5 with a concurrent enqueue
    add(0, 3, 32'h700, 32'h704, 0, 0, 0, 0, 2'b00, 0, 1, 0, 32'h0,   32'h0,   0);
    add(0, 3, 32'h708, 32'h70C, 0, 0, 0, 0, 2'b00, 2, 1, 3, 32'h700, 32'h704, 0);
    add(0, 1, 32'h710, 32'h0,   0, 0, 0, 0, 2'b00, 4, 1, 3, 32'h700, 32'h704, 0);
    add(1, 3, 32'h720, 32'h724, 0, 0, 0, 0, 2'b11, 5, 1, 3, 32'h700, 32'h704, 0);
    add(0, 0, 32'h0,   32'h0,   0, 0, 0, 0, 2'b00, 0, 1, 0, 32'h0,   32'h0,   0);
    // slot-2-only enqueue, then non-thermometer ready
    add(0, 2, 32'h7FC, 32'h400, 0, 0, 0, 0, 2'b00, 0, 1, 0, 32'h0,   32'h0,   0);
    add(0, 0, 32'h0,   32'h0,   0, 0, 0, 0, 2'b10, 1, 1, 1, 32'h400, 32'h0,   0);
    add(0, 0, 32'h0,   32'h0,   0, 0, 0, 0, 2'b01, 1, 1, 1, 32'h400, 32'h0,   0);
    add(0, 0, 32'h0,   32'h0,   0, 0, 0, 0, 2'b00, 0, 1, 0, 32'h0,   32'h0,   0);

    resetn = 1'b0;
    drive(1'b0, 2'b00, z, z, 2'b00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_enq_ready", 64'(enq_ready), 64'd1);
    chk("rst_deq_valid", 64'(deq_valid), 64'd0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    foreach (vt[i]) begin
      drive(vt[i].fl, vt[i].ev, mk(vt[i].pc1, vt[i].sp1, vt[i].ex1),
            mk(vt[i].pc2, vt[i].sp2, vt[i].ex2), vt[i].dr);
      @(negedge clk);
      model_check();
      chk($sformatf("v%0d_count", i), 64'(count), 64'(vt[i].cnt));
      chk($sformatf("v%0d_enq_ready", i), 64'(enq_ready), 64'(vt[i].er));
      chk($sformatf("v%0d_deq_valid", i), 64'(deq_valid), 64'(vt[i].dv));
      if (vt[i].dv[0]) begin
        exp_ex.ex      = vt[i].oex;
        exp_ex.exccode = vt[i].oex ? EXC_RI : 5'd0;
        chk($sformatf("v%0d_pc1", i), 64'(deq_pc1), 64'(vt[i].o1));
        chk($sformatf("v%0d_ex1", i), 64'(deq_ex1), 64'(exp_ex));
      end
      if (vt[i].dv[1]) begin
        chk($sformatf("v%0d_pc2", i), 64'(deq_pc2), 64'(vt[i].o2));
      end
      @(posedge clk);
      model_step();
      #1;
    end

    // Asynchronous reset in the middle of traffic clears state without a clock.
    run_cycle(1'b0, 2'b11, mk(32'h900, 0, 0), mk(32'h904, 0, 0), 2'b00);
    run_cycle(1'b0, 2'b11, mk(32'h908, 0, 0), mk(32'h90C, 0, 0), 2'b00);
    drive(1'b0, 2'b00, z, z, 2'b00);
    resetn = 1'b0;
    #2;
    chk("midrst_count", 64'(count), 64'd0);
    chk("midrst_enq_ready", 64'(enq_ready), 64'd1);
    chk("midrst_deq_valid", 64'(deq_valid), 64'd0);
    mq.delete();
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    run_cycle(1'b0, 2'b01, mk(32'hA00, 0, 0), z, 2'b00);
    run_cycle(1'b0, 2'b00, z, z, 2'b01);

    // Random traffic against the reference model.
    for (int k = 0; k < 3000; k++) begin
      tb_ent_t    r1, r2;
      logic       fl;
      r1.pc = $urandom; r1.inst.opcode = 16'($urandom);
      r1.inst.is_sp_op = ($urandom_range(0, 5) == 0);
      r1.ex.ex = ($urandom_range(0, 5) == 0); r1.ex.exccode = 5'($urandom);
      r2.pc = $urandom; r2.inst.opcode = 16'($urandom);
      r2.inst.is_sp_op = ($urandom_range(0, 5) == 0);
      r2.ex.ex = ($urandom_range(0, 5) == 0); r2.ex.exccode = 5'($urandom);
      fl = ($urandom_range(0, 63) == 0);
      run_cycle(fl, 2'($urandom), r1, r2, 2'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
